regfile_mp_sb: RTL and testbench
================================

// Module: regfile_mp_sb
// PURPOSE
//  Parametrised multi-port integer register file for the dual-issue pipeline, with an integrated scoreboard.
//  NRD combinational read ports; NWR synchronous write ports with write-through bypass.
//  Per-register pending-write counters report operand readiness to issue logic.
//  Sits between decode/issue (reads, reservations) and writeback (writes, releases).
// PARAMETERS
//  DATA_W  32  register width in bits
//  NREG    32  number of architectural registers; must be a power of two; register 0 is hardwired zero
//  NRD     4   number of read ports
//  NWR     2   number of write/issue lanes; a higher lane index is the younger instruction
//  PEND_W  2   width of each pending counter; max outstanding writes per register = 2**PEND_W-1
// PORTS
//  clk          in   1               clock; all state updates on posedge
//  rst          in   1               synchronous active-high reset
//  rd_addr      in   NRD x log2NREG  read addresses
//  rd_data      out  NRD x DATA_W    read data, combinational
//  rd_ready     out  NRD             operand has no outstanding producer (after this cycle's writebacks)
//  iss_en       in   NWR             lane issues an instruction that writes iss_addr
//  iss_addr     in   NWR x log2NREG  destination register being reserved
//  iss_ok       out  NWR             reservation accepted; iss_ok=0 requires issue to stall that lane
//  wb_en        in   NWR             writeback valid
//  wb_addr      in   NWR x log2NREG  writeback destination
//  wb_data      in   NWR x DATA_W    writeback data
//  flush        in   1               discard all reservations (pipeline flush)
//  sb_err       out  1               sticky: writeback to a register with a zero pending count
// BEHAVIOUR
//  Reset: all rf entries <= 0, all pending counters <= 0, sb_err <= 0.
//   Consequently rd_data=0 and rd_ready=1 for every port after reset.
//  Read data for port i:
//   rd_addr==0 -> 0.
//   Else, if any lane has wb_en && wb_addr==rd_addr, take wb_data of the highest such lane (bypass).
//   Else rf[rd_addr].
//  Write: at posedge, for each lane with wb_en and wb_addr!=0, rf[wb_addr] <= wb_data.
//   Same-address collision: the highest lane wins. Writes to r0 are dropped.
//  Pending counter cnt[r], r!=0 (cnt[0] is constant 0):
//   next = cnt - (#lanes wb_en to r, only while cnt>0) + (#lanes accepted iss to r).
//  iss_ok[k]: 1 when !iss_en[k], or when iss_addr[k]==0.
//   Otherwise iss_ok[k]=1 iff cnt[r] - wb_hits(r) + (#accepted lower lanes to r) < 2**PEND_W-1, where r=iss_addr[k].
//   Lanes are evaluated lowest first; a rejected lane does not update state.
//   iss_ok[k] is independent of flush.
//  Same-cycle issue and writeback to the same register: both apply; net change = issues - writebacks.
//  Writeback with cnt[r]==0 and r!=0: data is still written, the counter stays 0, and sb_err <= 1.
//   sb_err clears only on rst.
//  rd_ready[i] = (rd_addr==0) || (cnt[r] - wb_hits(r) == 0). Same-cycle issues do not affect rd_ready.
//  flush: all cnt <= 0 at the next posedge; it overrides that cycle's issues and releases.
//   Writebacks in the flush cycle still write rf, do not set sb_err, and rf contents are retained.
//  rst has priority over flush and over all writes.
//   Reset mid-operation discards every reservation and in-flight write.
//  Latency: reads 0 cycles; writes and counter updates are visible after 1 posedge, bypass covers the same cycle.
// CONFIGURATION
//  REGFILE_DEBUG_EN defined:
//   adds outputs dbg_wen[NWR], dbg_wa[NWR], dbg_wd[NWR]: the lane's wb_en, wb_addr and wb_data registered one cycle.
//   dbg_wen is forced to 0 for wb_addr==0 and for collision losers. Reset value is 0.
//  REGFILE_DEBUG_EN undefined: those ports and their flops do not exist; behaviour is otherwise identical.
// STRUCTURE
//  Package regfile_pkg:
//   reg_addr_t
//   parameter defaults DATA_W, NREG
//   function pend_max(PEND_W)
//   function prio_match(): highest matching lane
//  Sub-module regfile_scoreboard:
//   owns cnt[], iss_ok, rd_ready, sb_err, flush handling.
//   Ports: clk, rst, iss_*, wb_en/wb_addr, flush, rd_addr.
//  Top-level module: rf array, bypass muxes, write-collision resolution, debug flops.
// TESTING
//  1 Reset: after rst, read all 32 regs on 4 ports -> rd_data=0, rd_ready=1, sb_err=0.
//  2 Bypass priority: wb lane0 r5=0xAAAA and lane1 r5=0x5555 in the same cycle, read r5 -> 0x5555 that cycle;
//    next cycle rf[5]=0x5555. wb to r0 with 0xFFFF -> reads of r0 stay 0.
//  3 Scoreboard: issue r7 on lane0 -> next cycle rd_ready(r7)=0. wb r7 -> rd_ready=1 in the wb cycle.
//    Issue r7 on both lanes -> cnt=2; one wb -> still not ready.
//  4 Saturation: with PEND_W=2, issue r3 three times -> cnt=3.
//    A 4th issue gets iss_ok=0 and cnt stays 3. Issue plus wb to r3 in the same cycle -> iss_ok=1, cnt stays 3.
//  5 Flush and error: reserve r9 and r10, assert flush -> next cycle both ready.
//    A later wb r9=0x1234 writes data and sets sb_err=1, sticky until rst.
//  6 Reset mid-run: rst asserted with iss_en and wb_en active -> rf=0, all cnt=0, no write lands.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types, parameter defaults and helpers for regfile_mp_sb.
package regfile_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int NREG_DEF = 32;
  typedef logic [$clog2(NREG_DEF)-1:0] reg_addr_t;
  function automatic int pend_max(input int pend_w);
    return (1 << pend_w) - 1;
  endfunction
  function automatic int prio_match(input logic [31:0] hits);
    int idx;
    idx = -1;
    for (int k = 0; k < 32; k++) if (hits[k]) idx = k;
    return idx;
  endfunction
endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register pending-write counters, issue acceptance, operand readiness, sticky error.
module regfile_scoreboard import regfile_pkg::*; #(
  parameter int NREG = NREG_DEF,
  parameter int NRD = 4,
  parameter int NWR = 2,
  parameter int PEND_W = 2,
  localparam int AW = $clog2(NREG)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NWR-1:0]           iss_en,
  input  logic [NWR-1:0][AW-1:0]   iss_addr,
  output logic [NWR-1:0]           iss_ok,
  input  logic [NWR-1:0]           wb_en,
  input  logic [NWR-1:0][AW-1:0]   wb_addr,
  input  logic                     flush,
  input  logic [NRD-1:0][AW-1:0]   rd_addr,
  output logic [NRD-1:0]           rd_ready,
  output logic                     sb_err
);
  logic [PEND_W-1:0] cnt_q [NREG];
  logic [PEND_W-1:0] cnt_d [NREG];
  logic sb_err_q, sb_err_d;
  int hits [NREG];
  int base [NREG];
  int acc [NREG];
  // base is the count left after this cycle's releases; issues then stack on top lane by lane
  always_comb begin
    sb_err_d = sb_err_q;
    for (int r = 0; r < NREG; r++) begin
      hits[r] = 0;
      acc[r] = 0;
    end
    for (int k = 0; k < NWR; k++) if (wb_en[k]) hits[wb_addr[k]] = hits[wb_addr[k]] + 1;
    for (int r = 0; r < NREG; r++) begin
      base[r] = int'(cnt_q[r]) > hits[r] ? int'(cnt_q[r]) - hits[r] : 0;
      if (r != 0 && !flush && hits[r] > int'(cnt_q[r])) sb_err_d = 1'b1;
    end
    for (int k = 0; k < NWR; k++) begin
      iss_ok[k] = !iss_en[k] || iss_addr[k] == '0 || base[iss_addr[k]] + acc[iss_addr[k]] < pend_max(PEND_W);
      if (iss_en[k] && iss_addr[k] != '0 && iss_ok[k]) acc[iss_addr[k]] = acc[iss_addr[k]] + 1;
    end
    for (int r = 0; r < NREG; r++) cnt_d[r] = (flush || r == 0) ? '0 : PEND_W'(base[r] + acc[r]);
    for (int i = 0; i < NRD; i++) rd_ready[i] = rd_addr[i] == '0 || base[rd_addr[i]] == 0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '{default: '0};
      sb_err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sb_err_q <= sb_err_d;
    end
  end
  assign sb_err = sb_err_q;
endmodule

// File: rtl/regfile_mp_sb.sv
// regfile_mp_sb: multi-port register file with write-through bypass and scoreboard.
// Define REGFILE_DEBUG_EN to add registered writeback observation ports dbg_wen/dbg_wa/dbg_wd.
module regfile_mp_sb import regfile_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int NREG = NREG_DEF,
  parameter int NRD = 4,
  parameter int NWR = 2,
  parameter int PEND_W = 2,
  localparam int AW = $clog2(NREG)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NRD-1:0][AW-1:0]     rd_addr,
  output logic [NRD-1:0][DATA_W-1:0] rd_data,
  output logic [NRD-1:0]             rd_ready,
  input  logic [NWR-1:0]             iss_en,
  input  logic [NWR-1:0][AW-1:0]     iss_addr,
  output logic [NWR-1:0]             iss_ok,
  input  logic [NWR-1:0]             wb_en,
  input  logic [NWR-1:0][AW-1:0]     wb_addr,
  input  logic [NWR-1:0][DATA_W-1:0] wb_data,
  input  logic                       flush,
  output logic                       sb_err
`ifdef REGFILE_DEBUG_EN
  ,
  output logic [NWR-1:0]             dbg_wen,
  output logic [NWR-1:0][AW-1:0]     dbg_wa,
  output logic [NWR-1:0][DATA_W-1:0] dbg_wd
`endif
);
  logic [DATA_W-1:0] rf_q [NREG];
  logic [DATA_W-1:0] rf_d [NREG];
  logic [NWR-1:0] wb_win;
  logic [NRD-1:0][NWR-1:0] rd_hit;
  int rd_sel [NRD];
  // a lane's write lands only if it targets a real register and no younger lane hits the same one
  always_comb begin
    rf_d = rf_q;
    for (int k = 0; k < NWR; k++) begin
      wb_win[k] = wb_en[k] && wb_addr[k] != '0;
      for (int j = k + 1; j < NWR; j++) if (wb_en[j] && wb_addr[j] == wb_addr[k]) wb_win[k] = 1'b0;
      if (wb_win[k]) rf_d[wb_addr[k]] = wb_data[k];
    end
    for (int i = 0; i < NRD; i++) begin
      for (int k = 0; k < NWR; k++) rd_hit[i][k] = wb_en[k] && wb_addr[k] == rd_addr[i];
      rd_sel[i] = prio_match(32'(rd_hit[i]));
      rd_data[i] = rf_q[rd_addr[i]];
      for (int k = 0; k < NWR; k++) if (k == rd_sel[i]) rd_data[i] = wb_data[k];
      if (rd_addr[i] == '0) rd_data[i] = '0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) rf_q <= '{default: '0};
    else rf_q <= rf_d;
  end
  regfile_scoreboard #(.NREG(NREG), .NRD(NRD), .NWR(NWR), .PEND_W(PEND_W)) u_sb (
    .clk(clk), .rst(rst),
    .iss_en(iss_en), .iss_addr(iss_addr), .iss_ok(iss_ok),
    .wb_en(wb_en), .wb_addr(wb_addr),
    .flush(flush),
    .rd_addr(rd_addr), .rd_ready(rd_ready),
    .sb_err(sb_err)
  );
`ifdef REGFILE_DEBUG_EN
  logic [NWR-1:0] dbg_wen_q, dbg_wen_d;
  logic [NWR-1:0][AW-1:0] dbg_wa_q, dbg_wa_d;
  logic [NWR-1:0][DATA_W-1:0] dbg_wd_q, dbg_wd_d;
  always_comb begin
    dbg_wen_d = wb_win;
    dbg_wa_d = wb_addr;
    dbg_wd_d = wb_data;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      dbg_wen_q <= '0;
      dbg_wa_q <= '0;
      dbg_wd_q <= '0;
    end else begin
      dbg_wen_q <= dbg_wen_d;
      dbg_wa_q <= dbg_wa_d;
      dbg_wd_q <= dbg_wd_d;
    end
  end
  assign dbg_wen = dbg_wen_q;
  assign dbg_wa = dbg_wa_q;
  assign dbg_wd = dbg_wd_q;
`endif
endmodule

// File: tb/tb_regfile_mp_sb.sv
// tb_regfile_mp_sb: directed scenarios plus randomized run against a behavioural register-file/scoreboard model.
module tb_regfile_mp_sb;
  localparam int NRD = 4;
  localparam int NWR = 2;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 32;
  localparam int PMAX = 3;
  logic clk = 1'b0;
  logic rst, flush, sb_err;
  logic [NRD-1:0][AW-1:0] rd_addr;
  logic [NRD-1:0][DW-1:0] rd_data;
  logic [NRD-1:0] rd_ready;
  logic [NWR-1:0] iss_en, iss_ok, wb_en;
  logic [NWR-1:0][AW-1:0] iss_addr, wb_addr;
  logic [NWR-1:0][DW-1:0] wb_data;
`ifdef REGFILE_DEBUG_EN
  logic [NWR-1:0] dbg_wen;
  logic [NWR-1:0][AW-1:0] dbg_wa;
  logic [NWR-1:0][DW-1:0] dbg_wd;
`endif
  int n_chk = 0;
  int n_fail = 0;
  logic [DW-1:0] m_rf [NR];
  int m_cnt [NR];
  bit m_err;

  regfile_mp_sb dut (
    .clk(clk), .rst(rst),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_ready(rd_ready),
    .iss_en(iss_en), .iss_addr(iss_addr), .iss_ok(iss_ok),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .flush(flush), .sb_err(sb_err)
`ifdef REGFILE_DEBUG_EN
    , .dbg_wen(dbg_wen), .dbg_wa(dbg_wa), .dbg_wd(dbg_wd)
`endif
  );

  always #5 clk = ~clk;

  task automatic idle();
    rst = 1'b0;
    flush = 1'b0;
    iss_en = '0;
    iss_addr = '0;
    wb_en = '0;
    wb_addr = '0;
    wb_data = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  function automatic int hits(input int r);
    int n = 0;
    for (int k = 0; k < NWR; k++) if (wb_en[k] && int'(wb_addr[k]) == r) n++;
    return n;
  endfunction

  task automatic test_reset();
    do_reset();
    for (int b = 0; b < NR; b += NRD) begin
      for (int i = 0; i < NRD; i++) rd_addr[i] = AW'(b + i);
      #2;
      for (int i = 0; i < NRD; i++) begin
        n_chk++;
        if (rd_data[i] !== '0) begin
          n_fail++;
          $display("FAIL reset_data r%0d: got %h exp 0", b + i, rd_data[i]);
        end
        n_chk++;
        if (rd_ready[i] !== 1'b1) begin
          n_fail++;
          $display("FAIL reset_ready r%0d: got %b exp 1", b + i, rd_ready[i]);
        end
      end
    end
    n_chk++;
    if (sb_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_sb_err: got %b exp 0", sb_err);
    end
  endtask

  task automatic test_bypass();
    do_reset();
    wb_en = 2'b11;
    wb_addr[0] = 5'd5;
    wb_addr[1] = 5'd5;
    wb_data[0] = 32'hAAAA;
    wb_data[1] = 32'h5555;
    rd_addr = '0;
    rd_addr[0] = 5'd5;
    #2;
    n_chk++;
    if (rd_data[0] !== 32'h5555) begin
      n_fail++;
      $display("FAIL bypass_prio: got %h exp 00005555", rd_data[0]);
    end
    step();
    idle();
    #2;
    n_chk++;
    if (rd_data[0] !== 32'h5555) begin
      n_fail++;
      $display("FAIL collision_write: got %h exp 00005555", rd_data[0]);
    end
    wb_en = 2'b01;
    wb_addr[0] = 5'd0;
    wb_data[0] = 32'hFFFF;
    rd_addr[1] = 5'd0;
    #2;
    n_chk++;
    if (rd_data[1] !== '0) begin
      n_fail++;
      $display("FAIL r0_bypass: got %h exp 0", rd_data[1]);
    end
    step();
    idle();
    #2;
    n_chk++;
    if (rd_data[1] !== '0) begin
      n_fail++;
      $display("FAIL r0_write: got %h exp 0", rd_data[1]);
    end
  endtask

  task automatic test_scoreboard();
    do_reset();
    rd_addr = '0;
    rd_addr[0] = 5'd7;
    iss_en = 2'b01;
    iss_addr[0] = 5'd7;
    #2;
    n_chk++;
    if (iss_ok !== 2'b11) begin
      n_fail++;
      $display("FAIL sb_iss_ok: got %b exp 11", iss_ok);
    end
    n_chk++;
    if (rd_ready[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL sb_ready_issue_cycle: got %b exp 1", rd_ready[0]);
    end
    step();
    idle();
    #2;
    n_chk++;
    if (rd_ready[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL sb_ready_pending: got %b exp 0", rd_ready[0]);
    end
    wb_en = 2'b01;
    wb_addr[0] = 5'd7;
    #2;
    n_chk++;
    if (rd_ready[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL sb_ready_wb_cycle: got %b exp 1", rd_ready[0]);
    end
    step();
    idle();
    iss_en = 2'b11;
    iss_addr[0] = 5'd7;
    iss_addr[1] = 5'd7;
    #2;
    n_chk++;
    if (iss_ok !== 2'b11) begin
      n_fail++;
      $display("FAIL sb_dual_iss_ok: got %b exp 11", iss_ok);
    end
    step();
    idle();
    wb_en = 2'b01;
    wb_addr[0] = 5'd7;
    #2;
    n_chk++;
    if (rd_ready[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL sb_cnt2_one_wb: got %b exp 0", rd_ready[0]);
    end
    step();
    idle();
    wb_en = 2'b10;
    wb_addr[1] = 5'd7;
    step();
    idle();
    #2;
    n_chk++;
    if (rd_ready[0] !== 1'b1 || sb_err !== 1'b0) begin
      n_fail++;
      $display("FAIL sb_drain: got ready=%b err=%b exp ready=1 err=0", rd_ready[0], sb_err);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    rd_addr = '0;
    rd_addr[0] = 5'd3;
    iss_en = 2'b11;
    iss_addr[0] = 5'd3;
    iss_addr[1] = 5'd3;
    step();
    idle();
    iss_en = 2'b01;
    iss_addr[0] = 5'd3;
    #2;
    n_chk++;
    if (iss_ok[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_third_iss: got %b exp 1", iss_ok[0]);
    end
    step();
    #2;
    n_chk++;
    if (iss_ok[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL sat_fourth_iss: got %b exp 0", iss_ok[0]);
    end
    step();
    wb_en = 2'b10;
    wb_addr[1] = 5'd3;
    #2;
    n_chk++;
    if (iss_ok[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_iss_with_wb: got %b exp 1", iss_ok[0]);
    end
    step();
    idle();
    for (int n = 0; n < PMAX; n++) begin
      wb_en = 2'b01;
      wb_addr[0] = 5'd3;
      #2;
      n_chk++;
      if (rd_ready[0] !== (n == PMAX - 1)) begin
        n_fail++;
        $display("FAIL sat_drain_%0d: got %b exp %b", n, rd_ready[0], n == PMAX - 1);
      end
      step();
      idle();
    end
    #2;
    n_chk++;
    if (sb_err !== 1'b0) begin
      n_fail++;
      $display("FAIL sat_no_err: got %b exp 0", sb_err);
    end
  endtask

  task automatic test_flush_err();
    do_reset();
    iss_en = 2'b11;
    iss_addr[0] = 5'd9;
    iss_addr[1] = 5'd10;
    step();
    idle();
    flush = 1'b1;
    iss_en = 2'b01;
    iss_addr[0] = 5'd9;
    wb_en = 2'b10;
    wb_addr[1] = 5'd11;
    wb_data[1] = 32'hBEEF;
    #2;
    n_chk++;
    if (iss_ok[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_iss_ok: got %b exp 1", iss_ok[0]);
    end
    step();
    idle();
    rd_addr[0] = 5'd9;
    rd_addr[1] = 5'd10;
    rd_addr[2] = 5'd11;
    rd_addr[3] = 5'd0;
    #2;
    n_chk++;
    if (rd_ready !== 4'hF || sb_err !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_ready: got ready=%b err=%b exp ready=1111 err=0", rd_ready, sb_err);
    end
    n_chk++;
    if (rd_data[2] !== 32'hBEEF) begin
      n_fail++;
      $display("FAIL flush_cycle_write: got %h exp 0000beef", rd_data[2]);
    end
    wb_en = 2'b01;
    wb_addr[0] = 5'd9;
    wb_data[0] = 32'h1234;
    step();
    idle();
    #2;
    n_chk++;
    if (rd_data[0] !== 32'h1234 || sb_err !== 1'b1) begin
      n_fail++;
      $display("FAIL err_wb: got data=%h err=%b exp data=00001234 err=1", rd_data[0], sb_err);
    end
    repeat (3) step();
    n_chk++;
    if (sb_err !== 1'b1) begin
      n_fail++;
      $display("FAIL err_sticky: got %b exp 1", sb_err);
    end
  endtask

  task automatic test_reset_mid();
    iss_en = 2'b01;
    iss_addr[0] = 5'd4;
    wb_en = 2'b11;
    wb_addr[0] = 5'd12;
    wb_data[0] = 32'hCAFE;
    wb_addr[1] = 5'd9;
    wb_data[1] = 32'hFFFF;
    rst = 1'b1;
    step();
    idle();
    rd_addr[0] = 5'd9;
    rd_addr[1] = 5'd12;
    rd_addr[2] = 5'd4;
    rd_addr[3] = 5'd11;
    #2;
    n_chk++;
    if (rd_data !== '0) begin
      n_fail++;
      $display("FAIL rst_mid_data: got %h exp 0", rd_data);
    end
    n_chk++;
    if (rd_ready !== 4'hF || sb_err !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_sb: got ready=%b err=%b exp ready=1111 err=0", rd_ready, sb_err);
    end
  endtask

  task automatic test_random();
    int acc [NR];
    int a, h, b;
    bit ok;
    logic [DW-1:0] e;
    do_reset();
    for (int r = 0; r < NR; r++) begin
      m_rf[r] = '0;
      m_cnt[r] = 0;
    end
    m_err = 1'b0;
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 59) == 0);
      flush = ($urandom_range(0, 14) == 0);
      for (int k = 0; k < NWR; k++) begin
        iss_en[k] = 1'($urandom_range(0, 1));
        iss_addr[k] = AW'($urandom_range(0, 7));
        wb_en[k] = 1'($urandom_range(0, 1));
        wb_addr[k] = AW'($urandom_range(0, 7));
        wb_data[k] = $urandom;
      end
      for (int i = 0; i < NRD; i++) rd_addr[i] = AW'($urandom_range(0, 8));
      #2;
      for (int i = 0; i < NRD; i++) begin
        a = int'(rd_addr[i]);
        e = m_rf[a];
        for (int k = 0; k < NWR; k++) if (wb_en[k] && int'(wb_addr[k]) == a) e = wb_data[k];
        if (a == 0) e = '0;
        n_chk++;
        if (rd_data[i] !== e) begin
          n_fail++;
          $display("FAIL rand_data c%0d p%0d r%0d: got %h exp %h", c, i, a, rd_data[i], e);
        end
        n_chk++;
        if (rd_ready[i] !== (a == 0 || m_cnt[a] <= hits(a))) begin
          n_fail++;
          $display("FAIL rand_ready c%0d p%0d r%0d: got %b exp %b", c, i, a, rd_ready[i], a == 0 || m_cnt[a] <= hits(a));
        end
      end
      for (int r = 0; r < NR; r++) acc[r] = 0;
      for (int k = 0; k < NWR; k++) begin
        a = int'(iss_addr[k]);
        b = m_cnt[a] > hits(a) ? m_cnt[a] - hits(a) : 0;
        ok = !iss_en[k] || a == 0 || b + acc[a] < PMAX;
        n_chk++;
        if (iss_ok[k] !== ok) begin
          n_fail++;
          $display("FAIL rand_iss_ok c%0d l%0d r%0d: got %b exp %b", c, k, a, iss_ok[k], ok);
        end
        if (iss_en[k] && a != 0 && ok) acc[a]++;
      end
      n_chk++;
      if (sb_err !== m_err) begin
        n_fail++;
        $display("FAIL rand_sb_err c%0d: got %b exp %b", c, sb_err, m_err);
      end
      step();
      if (rst) begin
        for (int r = 0; r < NR; r++) begin
          m_rf[r] = '0;
          m_cnt[r] = 0;
        end
        m_err = 1'b0;
      end else begin
        for (int k = 0; k < NWR; k++) if (wb_en[k] && wb_addr[k] != '0) m_rf[wb_addr[k]] = wb_data[k];
        for (int r = 1; r < NR; r++) begin
          h = hits(r);
          if (!flush && h > m_cnt[r]) m_err = 1'b1;
          m_cnt[r] = flush ? 0 : (m_cnt[r] > h ? m_cnt[r] - h : 0) + acc[r];
        end
      end
    end
    idle();
  endtask

  initial begin
    idle();
    rd_addr = '0;
    test_reset();
    test_bypass();
    test_scoreboard();
    test_saturation();
    test_flush_err();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
